// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the toggle req/ack handshake crossing (tx and rx ends).
package cdc_hs_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } hs_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_sync_chain.sv
// Plain flop chain synchronizer for a single asynchronous level/toggle signal.
module cdc_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_l_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit end of a 2-phase toggle req/ack crossing: holds a payload, toggles req,
// and waits for the synchronized ack toggle before accepting the next payload.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  rclk,
  input  logic                  rst_l,
  input  logic                  in_val,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_rdy,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  ack_async,
  output logic                  xfer_done,
  output logic                  busy,
  output logic                  err_timeout,
  input  logic                  err_clr
);

  localparam int TW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  hs_state_e             state_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [TW-1:0]         timer_q;
  logic [TW-1:0]         timer_d;
  logic                  done_q;
  logic                  err_q;
  logic                  run_q;
  logic                  ack_s;
  logic                  ack_match;
  logic                  timeout_hit;

  cdc_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i   (rclk),
    .rst_l_i (rst_l),
    .d_i     (ack_async),
    .q_o     (ack_s)
  );

  // run_q keeps in_rdy low while reset is held, without a path from rst_l to the output.
  assign ack_match   = (ack_s == req_q);
  assign in_rdy      = run_q & (state_q == IDLE) & ack_match;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TLAST);

  always_comb begin
    timer_d = timer_q;
    if ((TIMEOUT_CYC != 0) && (timer_q != TMAX)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      done_q <= 1'b0;
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (in_val && in_rdy) begin
            data_q  <= in_data;
            req_q   <= ~req_q;
            timer_q <= '0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_match) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            timer_q <= timer_d;
            // a late set overrides a same-cycle err_clr
            if (timeout_hit) begin
              err_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign xfer_done   = done_q;
  assign busy        = (state_q == WAIT_ACK);
  assign err_timeout = err_q;

endmodule
